// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results go straight to the write
// port, LSU results go through an in-order FIFO, and a bounded stall stops the FIFO starving.
module rf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_STALL  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [4:0]                    i_alu_rd,
  input  logic [31:0]                   i_alu_data,
  input  logic                          i_lsu_valid,
  output logic                          o_lsu_ready,
  input  logic [4:0]                    i_lsu_rd,
  input  logic [31:0]                   i_lsu_data,
  output logic                          o_rd_wen,
  output logic [4:0]                    o_rd_waddr,
  output logic [31:0]                   o_rd_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [31:0]                   o_pending_mask
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  logic [4:0]            ent_rd_q   [FIFO_DEPTH];
  logic [31:0]           ent_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld_q;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               rd_wen_q, rd_wen_d;
  logic [4:0]         rd_waddr_q, rd_waddr_d;
  logic [31:0]        rd_wdata_q, rd_wdata_d;

  logic fifo_ne_c;
  logic stall_max_c;
  logic pop_c;
  logic alu_gnt_c;
  logic push_c;

  // Grant selection: the FIFO head wins when the ALU is idle or has used up its stall budget.
  assign fifo_ne_c   = (count_q != '0);
  assign stall_max_c = (stall_q == STALL_W'(MAX_STALL));
  assign pop_c       = fifo_ne_c && (stall_max_c || !i_alu_valid);
  assign alu_gnt_c   = i_alu_valid && !pop_c;
  assign o_alu_ready = !(fifo_ne_c && stall_max_c);
  assign o_lsu_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push_c      = i_lsu_valid && o_lsu_ready && (i_lsu_rd != 5'd0);

  assign o_fifo_count = count_q;
  assign o_rd_wen     = rd_wen_q;
  assign o_rd_waddr   = rd_waddr_q;
  assign o_rd_wdata   = rd_wdata_q;

  always_comb begin
    o_pending_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (ent_vld_q[i]) o_pending_mask[ent_rd_q[i]] = 1'b1;
    end
    o_pending_mask[0] = 1'b0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    stall_d    = stall_q;
    rd_wen_d   = 1'b0;
    rd_waddr_d = rd_waddr_q;
    rd_wdata_d = rd_wdata_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Budget only accrues while an LSU result is actually waiting.
    if (pop_c || !fifo_ne_c) begin
      stall_d = '0;
    end else if (alu_gnt_c && !stall_max_c) begin
      stall_d = stall_q + STALL_W'(1);
    end

    if (pop_c) begin
      rd_wen_d   = (ent_rd_q[rd_ptr_q] != 5'd0);
      rd_waddr_d = ent_rd_q[rd_ptr_q];
      rd_wdata_d = ent_data_q[rd_ptr_q];
    end else if (alu_gnt_c) begin
      rd_wen_d   = (i_alu_rd != 5'd0);
      rd_waddr_d = i_alu_rd;
      rd_wdata_d = i_alu_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      rd_wen_q   <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      ent_vld_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      rd_wen_q   <= rd_wen_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
      // Push and pop never address the same slot: pop needs non-empty, push needs non-full.
      if (pop_c) ent_vld_q[rd_ptr_q] <= 1'b0;
      if (push_c) begin
        ent_vld_q[wr_ptr_q]  <= 1'b1;
        ent_rd_q[wr_ptr_q]   <= i_lsu_rd;
        ent_data_q[wr_ptr_q] <= i_lsu_data;
      end
    end
  end

endmodule
